lsu_hs: RTL and testbench

- Parametrised, handshaked successor to the single-cycle load/store unit. Serves one load/store request at a time over a valid/ready request channel and a valid/ready response channel.
- Backing storage:
  - synchronous-read data memory with byte enables;
  - N_OUT 32-bit output peripheral registers;
  - N_IN 32-bit input channels, each passed through a two-flop synchroniser.
- Sits between the core's MEM stage and the memory/IO map, and adds misalignment and unmapped-address error reporting.

---
 rtl/lsu_hs_pkg.sv | 59 +++++
 rtl/lsu_hs_align.sv | 70 +++++++
 rtl/lsu_hs.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_lsu_hs.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_hs_pkg.sv
// lsu_hs_pkg: shared types and helpers for the handshaked load/store unit.
// Optional feature macro used by the unit: LSU_HS_UNMAPPED_ERR_EN.
package lsu_hs_pkg;

    // Access size encoding carried in req_op_i[1:0]
    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    // Decoded target of an access; RGN_NONE covers every unmapped case
    typedef enum logic [1:0] {
        RGN_DMEM = 2'b00,
        RGN_OUT  = 2'b01,
        RGN_IN   = 2'b10,
        RGN_NONE = 2'b11
    } region_e;

    // Transaction sequencing
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    // Address nibble [15:12] of each mapped region
    localparam logic [3:0] NIB_DMEM = 4'h0;
    localparam logic [3:0] NIB_OUT  = 4'h7;
    localparam logic [3:0] NIB_IN   = 4'h8;

    // Byte lanes touched by an access of the given size at the given byte offset
    function automatic logic [3:0] byte_mask(input size_e size, input logic [1:0] lane);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SZ_B:    m = 4'b0001 << lane;
            SZ_H:    m = lane[1] ? 4'b1100 : 4'b0011;
            SZ_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // True when the offset is not a multiple of the access size (illegal size counts too)
    function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
        logic bad;
        bad = 1'b1;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lane[0];
            SZ_W:    bad = |lane;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_hs_align.sv
// lsu_hs_align: store-data lane replication and load lane extraction with
// sign/zero extension. Purely combinational; shared by all regions.
module lsu_hs_align
    import lsu_hs_pkg::*;
(
    input  size_e       size_i,
    input  logic        zext_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [31:0] wrep_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Replicate LSB-aligned store data onto every lane; the byte mask picks the live ones
    always_comb begin
        wrep_o = 32'h0000_0000;
        case (size_i)
            SZ_B:    wrep_o = {4{wdata_i[7:0]}};
            SZ_H:    wrep_o = {2{wdata_i[15:0]}};
            SZ_W:    wrep_o = wdata_i;
            default: wrep_o = 32'h0000_0000;
        endcase
    end

    // Pick the addressed byte and half-word out of the read word
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (lane_i)
            2'd0:    byte_s = rword_i[7:0];
            2'd1:    byte_s = rword_i[15:8];
            2'd2:    byte_s = rword_i[23:16];
            2'd3:    byte_s = rword_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane_i[1]) begin
            half_s = rword_i[31:16];
        end else begin
            half_s = rword_i[15:0];
        end
    end

    // Extend the selected lanes to 32 bits
    always_comb begin
        rdata_o = 32'h0000_0000;
        case (size_i)
            SZ_B: begin
                if (zext_i) begin
                    rdata_o = {24'h00_0000, byte_s};
                end else begin
                    rdata_o = {{24{byte_s[7]}}, byte_s};
                end
            end
            SZ_H: begin
                if (zext_i) begin
                    rdata_o = {16'h0000, half_s};
                end else begin
                    rdata_o = {{16{half_s[15]}}, half_s};
                end
            end
            SZ_W:    rdata_o = rword_i;
            default: rdata_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_hs.sv
// lsu_hs: handshaked load/store unit with data memory, output peripheral
// registers and synchronised input channels. One transaction at a time:
// IDLE (accept) -> ACCESS (write / issue read) -> RESP (hold until consumed).
// Build option LSU_HS_UNMAPPED_ERR_EN: when defined, unmapped accesses flag
// rsp_err_o; when undefined they complete quietly (loads return 0).
module lsu_hs
    import lsu_hs_pkg::*;
#(
    parameter int DMEM_AW = 8,
    parameter int N_OUT   = 11,
    parameter int N_IN    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [31:0]           req_addr_i,
    input  logic [2:0]            req_op_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    input  logic [N_IN*32-1:0]    io_in_i,
    output logic [N_OUT*32-1:0]   io_out_o
);

    localparam int          DMEM_DEPTH = 1 << DMEM_AW;
    localparam logic [31:0] N_OUT_W    = 32'(N_OUT);
    localparam logic [31:0] N_IN_W     = 32'(N_IN);

    // FSM
    state_e state_q, state_d;
    logic   hs_s;

    // Captured request
    logic               we_q;
    logic [2:0]         op_q;
    logic [1:0]         lane_q;
    logic [DMEM_AW-1:0] didx_q;
    logic [5:0]         pidx_q;
    logic [31:0]        wdata_q;
    logic               err_q;
    region_e            region_q;

    // Request-side decode
    region_e     region_s;
    logic [31:0] req_pidx_s;
    logic        unmapped_err_s;
    logic        err_s;

    // Storage
    logic [31:0] dmem_q [DMEM_DEPTH];
    logic [31:0] dmem_rd_q;
    logic [31:0] periph_rd_q;
    logic [31:0] periph_mux_s;
    logic [31:0] out_q   [N_OUT];
    logic [31:0] sync1_q [N_IN];
    logic [31:0] sync2_q [N_IN];

    // Datapath
    logic        acc_s;
    logic        wr_s;
    logic [3:0]  be_s;
    logic [31:0] rword_s;
    logic [31:0] wrep_s;
    logic [31:0] load_s;
    logic        unused_s;

    // Address bits outside the decoded fields have no function
    assign unused_s = ^req_addr_i;

    assign hs_s  = req_valid_i & req_ready_o;
    assign acc_s = (state_q == ST_ACCESS);
    assign wr_s  = acc_s & we_q & ~err_q;
    assign be_s  = byte_mask(size_e'(op_q[1:0]), lane_q);

    // Decode target region of the incoming request; out-of-range indices and input-region stores are unmapped
    always_comb begin
        region_s   = RGN_NONE;
        req_pidx_s = {26'd0, req_addr_i[7:2]};
        case (req_addr_i[15:12])
            NIB_DMEM: region_s = RGN_DMEM;
            NIB_OUT: begin
                if (req_pidx_s < N_OUT_W) begin
                    region_s = RGN_OUT;
                end else begin
                    region_s = RGN_NONE;
                end
            end
            NIB_IN: begin
                if (!req_we_i && (req_pidx_s < N_IN_W)) begin
                    region_s = RGN_IN;
                end else begin
                    region_s = RGN_NONE;
                end
            end
            default: region_s = RGN_NONE;
        endcase
    end

    // Error flag for the incoming request; unmapped counts only when the build option is on
    always_comb begin
`ifdef LSU_HS_UNMAPPED_ERR_EN
        unmapped_err_s = (region_s == RGN_NONE);
`else
        unmapped_err_s = 1'b0;
`endif
        err_s = is_misaligned(size_e'(req_op_i[1:0]), req_addr_i[1:0]) | unmapped_err_s;
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hs_s) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; response fields come only from registers held stable in RESP
    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_rdata_o = 32'h0000_0000;
        rsp_err_o   = 1'b0;
        if ((state_q == ST_IDLE) && !rst_i) begin
            req_ready_o = 1'b1;
        end else begin
            req_ready_o = 1'b0;
        end
        if (state_q == ST_RESP) begin
            rsp_valid_o = 1'b1;
            rsp_err_o   = err_q;
            if (we_q || err_q) begin
                rsp_rdata_o = 32'h0000_0000;
            end else begin
                rsp_rdata_o = load_s;
            end
        end else begin
            rsp_valid_o = 1'b0;
            rsp_err_o   = 1'b0;
            rsp_rdata_o = 32'h0000_0000;
        end
    end

    // Capture the request on the handshake; req_* are ignored in any other state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q     <= 1'b0;
            op_q     <= 3'b000;
            lane_q   <= 2'b00;
            didx_q   <= {DMEM_AW{1'b0}};
            pidx_q   <= 6'd0;
            wdata_q  <= 32'h0000_0000;
            err_q    <= 1'b0;
            region_q <= RGN_NONE;
        end else if (hs_s) begin
            we_q     <= req_we_i;
            op_q     <= req_op_i;
            lane_q   <= req_addr_i[1:0];
            didx_q   <= req_addr_i[DMEM_AW+1:2];
            pidx_q   <= req_addr_i[7:2];
            wdata_q  <= req_wdata_i;
            err_q    <= err_s;
            region_q <= region_s;
        end else begin
            we_q     <= we_q;
            region_q <= region_q;
        end
    end

    // Data memory: byte-enabled write and synchronous read at the ACCESS edge (no reset on contents)
    always_ff @(posedge clk_i) begin
        if (wr_s && (region_q == RGN_DMEM)) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    dmem_q[didx_q][8*b +: 8] <= wrep_s[8*b +: 8];
                end
            end
        end
        if (acc_s && !we_q) begin
            dmem_rd_q <= dmem_q[didx_q];
        end
    end

    // Select the peripheral word addressed by the captured index
    always_comb begin
        periph_mux_s = 32'h0000_0000;
        if (region_q == RGN_OUT) begin
            for (int k = 0; k < N_OUT; k++) begin
                periph_mux_s = (pidx_q == 6'(k)) ? out_q[k] : periph_mux_s;
            end
        end else if (region_q == RGN_IN) begin
            for (int k = 0; k < N_IN; k++) begin
                periph_mux_s = (pidx_q == 6'(k)) ? sync2_q[k] : periph_mux_s;
            end
        end else begin
            periph_mux_s = 32'h0000_0000;
        end
    end

    // Output registers take byte-enabled writes; peripheral loads are registered at the ACCESS edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_OUT; k++) begin
                out_q[k] <= 32'h0000_0000;
            end
            periph_rd_q <= 32'h0000_0000;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (wr_s && (region_q == RGN_OUT) && (pidx_q == 6'(k))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be_s[b]) begin
                            out_q[k][8*b +: 8] <= wrep_s[8*b +: 8];
                        end
                    end
                end
            end
            if (acc_s && !we_q) begin
                periph_rd_q <= periph_mux_s;
            end else begin
                periph_rd_q <= periph_rd_q;
            end
        end
    end

    // Two-flop synchronisers for the asynchronous input channels
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_IN; k++) begin
                sync1_q[k] <= 32'h0000_0000;
                sync2_q[k] <= 32'h0000_0000;
            end
        end else begin
            for (int k = 0; k < N_IN; k++) begin
                sync1_q[k] <= io_in_i[32*k +: 32];
                sync2_q[k] <= sync1_q[k];
            end
        end
    end

    // Raw read word for the response, chosen by the captured region
    always_comb begin
        rword_s = 32'h0000_0000;
        case (region_q)
            RGN_DMEM: rword_s = dmem_rd_q;
            RGN_OUT:  rword_s = periph_rd_q;
            RGN_IN:   rword_s = periph_rd_q;
            default:  rword_s = 32'h0000_0000;
        endcase
    end

    lsu_hs_align u_align (
        .size_i  (size_e'(op_q[1:0])),
        .zext_i  (op_q[2]),
        .lane_i  (lane_q),
        .wdata_i (wdata_q),
        .rword_i (rword_s),
        .wrep_o  (wrep_s),
        .rdata_o (load_s)
    );

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign io_out_o[32*g +: 32] = out_q[g];
    end

endmodule

// File: tb/tb_lsu_hs.sv
// tb_lsu_hs: randomized and directed self-checking bench for lsu_hs against a
// byte-addressed behavioural model of the memory/IO map.
module tb_lsu_hs;

    localparam int DMEM_AW = 8;
    localparam int N_OUT   = 11;
    localparam int N_IN    = 1;
    localparam int DM_BYTES = 4 * (1 << DMEM_AW);
`ifdef LSU_HS_UNMAPPED_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [31:0]         req_addr;
    logic [2:0]          req_op;
    logic [31:0]         req_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_rdata;
    logic                rsp_err;
    logic [N_IN*32-1:0]  io_in;
    logic [N_OUT*32-1:0] io_out;

    int tests_run;
    int tests_failed;

    // Behavioural model state
    logic [7:0]  mem_m [DM_BYTES];
    logic [31:0] out_m [N_OUT];

    lsu_hs #(.DMEM_AW(DMEM_AW), .N_OUT(N_OUT), .N_IN(N_IN)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_op_i    (req_op),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .io_in_i     (io_in),
        .io_out_o    (io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [N_OUT*32-1:0] exp_io();
        logic [N_OUT*32-1:0] r;
        for (int k = 0; k < N_OUT; k++) r[32*k +: 32] = out_m[k];
        return r;
    endfunction

    // Apply one access to the model: byte-addressed view of the map
    task automatic model_access(input logic we, input logic [31:0] a, input logic [2:0] op,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int n;
        int idx;
        int lane;
        int ba;
        logic [3:0] rgn;
        bit mapped;
        logic [31:0] v;
        rd = 32'h0;
        er = 1'b0;
        if (op[1:0] == 2'b11) begin er = 1'b1; return; end
        n = 1 << op[1:0];
        if ((a % n) != 0) begin er = 1'b1; return; end
        rgn = a[15:12];
        idx = int'(a[7:2]);
        mapped = (rgn == 4'h0) || (rgn == 4'h7 && idx < N_OUT) || (rgn == 4'h8 && idx < N_IN && !we);
        if (!mapped) begin er = ERR_EN; return; end
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
            lane = int'(a[1:0]) + i;
            if (rgn == 4'h0) begin
                ba = int'(a % DM_BYTES) + i;
                if (we) mem_m[ba] = wd[8*i +: 8];
                else    v[8*i +: 8] = mem_m[ba];
            end else if (rgn == 4'h7) begin
                if (we) out_m[idx][8*lane +: 8] = wd[8*i +: 8];
                else    v[8*i +: 8] = out_m[idx][8*lane +: 8];
            end else begin
                v[8*i +: 8] = io_in[32*idx + 8*lane +: 8];
            end
        end
        if (!we) begin
            if (!op[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            rd = v;
        end
    endtask

    // Drive one request through the DUT; lat = edges after the accept edge until rsp_valid is seen
    task automatic do_txn(input logic we, input logic [31:0] a, input logic [2:0] op,
                          input logic [31:0] wd, input int hold,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic [N_OUT*32-1:0] io_snap);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        req_valid = 1'b1; req_we = we; req_addr = a; req_op = op; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
        req_op = 3'($urandom); req_wdata = $urandom;
        lat = 0;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        rd = rsp_rdata; er = rsp_err; io_snap = io_out;
        repeat (hold) @(posedge clk);
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    // Model and DUT side by side for one transaction
    task automatic run_txn(input logic we, input logic [31:0] a, input logic [2:0] op,
                           input logic [31:0] wd, input int hold,
                           output logic [31:0] rd, output logic er, output int lat,
                           output logic [N_OUT*32-1:0] io_snap,
                           output logic [31:0] erd, output logic eer);
        model_access(we, a, op, wd, erd, eer);
        do_txn(we, a, op, wd, hold, rd, er, lat, io_snap);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== 35'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ready=%b valid=%b err=%b rdata=%h, want all 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        tests_run++;
        if (io_out !== '0) begin
            tests_failed++;
            $display("FAIL reset_io_out: got %h, want 0", io_out);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b, want 1", req_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        logic [N_OUT*32-1:0] snap;
        run_txn(1'b1, 32'h0000_0010, 3'b010, 32'hDEAD_BEEF, 0, rd, er, lat, snap, erd, eer);
        tests_run++;
        if ({er, rd, lat} !== {1'b0, 32'h0, 32'd1}) begin
            tests_failed++;
            $display("FAIL store_word: got err=%b rdata=%h lat=%0d, want 0 0 1", er, rd, lat);
        end
        run_txn(1'b0, 32'h0000_0010, 3'b010, 32'h0, 0, rd, er, lat, snap, erd, eer);
        tests_run++;
        if ({er, rd, lat} !== {1'b0, 32'hDEAD_BEEF, 32'd1}) begin
            tests_failed++;
            $display("FAIL load_word: got err=%b rdata=%h lat=%0d, want 0 deadbeef 1", er, rd, lat);
        end
        run_txn(1'b0, 32'h0000_0013, 3'b000, 32'h0, 1, rd, er, lat, snap, erd, eer);
        tests_run++;
        if ({er, rd} !== {1'b0, 32'hFFFF_FFDE}) begin
            tests_failed++;
            $display("FAIL load_byte_sext: got err=%b rdata=%h, want 0 ffffffde", er, rd);
        end
        run_txn(1'b0, 32'h0000_0013, 3'b100, 32'h0, 0, rd, er, lat, snap, erd, eer);
        tests_run++;
        if ({er, rd} !== {1'b0, 32'h0000_00DE}) begin
            tests_failed++;
            $display("FAIL load_byte_zext: got err=%b rdata=%h, want 0 000000de", er, rd);
        end
        run_txn(1'b0, 32'h0000_0012, 3'b001, 32'h0, 0, rd, er, lat, snap, erd, eer);
        tests_run++;
        if ({er, rd} !== {1'b0, 32'hFFFF_DEAD}) begin
            tests_failed++;
            $display("FAIL load_half_sext: got err=%b rdata=%h, want 0 ffffdead", er, rd);
        end
        run_txn(1'b1, 32'h0000_7008, 3'b001, 32'hCAFE_1234, 0, rd, er, lat, snap, erd, eer);
        tests_run++;
        if ({er, snap[64 +: 32]} !== {1'b0, 32'h0000_1234}) begin
            tests_failed++;
            $display("FAIL out_half_store: got err=%b ch2=%h, want 0 00001234", er, snap[64 +: 32]);
        end
        tests_run++;
        if (snap !== exp_io()) begin
            tests_failed++;
            $display("FAIL out_other_channels: got %h, want %h", snap, exp_io());
        end
    endtask

    task automatic test_input();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        logic [N_OUT*32-1:0] snap;
        io_in = 32'h0000_005A;
        repeat (3) @(posedge clk);
        run_txn(1'b0, 32'h0000_8000, 3'b010, 32'h0, 0, rd, er, lat, snap, erd, eer);
        tests_run++;
        if ({er, rd} !== {1'b0, 32'h0000_005A}) begin
            tests_failed++;
            $display("FAIL input_load: got err=%b rdata=%h, want 0 0000005a", er, rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        logic [N_OUT*32-1:0] snap;
        run_txn(1'b0, 32'h0000_0002, 3'b010, 32'h0, 0, rd, er, lat, snap, erd, eer);
        tests_run++;
        if ({er, rd} !== {1'b1, 32'h0}) begin
            tests_failed++;
            $display("FAIL misaligned_load: got err=%b rdata=%h, want 1 0", er, rd);
        end
        run_txn(1'b1, 32'h0000_9000, 3'b010, 32'h1111_2222, 0, rd, er, lat, snap, erd, eer);
        tests_run++;
        if ({er, rd} !== {ERR_EN, 32'h0}) begin
            tests_failed++;
            $display("FAIL unmapped_store: got err=%b rdata=%h, want %b 0", er, rd, ERR_EN);
        end
        run_txn(1'b1, 32'h0000_8000, 3'b010, 32'h3333_4444, 0, rd, er, lat, snap, erd, eer);
        tests_run++;
        if (er !== ERR_EN) begin
            tests_failed++;
            $display("FAIL input_store: got err=%b, want %b", er, ERR_EN);
        end
        run_txn(1'b0, 32'h0000_702C, 3'b010, 32'h0, 0, rd, er, lat, snap, erd, eer);
        tests_run++;
        if ({er, rd} !== {ERR_EN, 32'h0}) begin
            tests_failed++;
            $display("FAIL out_index_oob: got err=%b rdata=%h, want %b 0", er, rd, ERR_EN);
        end
        run_txn(1'b1, 32'h0000_0011, 3'b010, 32'h5555_6666, 0, rd, er, lat, snap, erd, eer);
        tests_run++;
        if (er !== 1'b1) begin
            tests_failed++;
            $display("FAIL misaligned_store: got err=%b, want 1", er);
        end
        run_txn(1'b1, 32'h0000_0010, 3'b011, 32'h7777_8888, 0, rd, er, lat, snap, erd, eer);
        tests_run++;
        if (er !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_size: got err=%b, want 1", er);
        end
        run_txn(1'b0, 32'h0000_0010, 3'b010, 32'h0, 0, rd, er, lat, snap, erd, eer);
        tests_run++;
        if ({er, rd} !== {1'b0, 32'hDEAD_BEEF}) begin
            tests_failed++;
            $display("FAIL mem_unchanged: got err=%b rdata=%h, want 0 deadbeef", er, rd);
        end
        run_txn(1'b0, 32'h0000_0000, 3'b010, 32'h0, 0, rd, er, lat, snap, erd, eer);
        tests_run++;
        if ({er, rd} !== {eer, erd}) begin
            tests_failed++;
            $display("FAIL mem_word0_unchanged: got err=%b rdata=%h, want %b %h", er, rd, eer, erd);
        end
    endtask

    task automatic test_stall();
        logic [31:0] erd, rd, junk;
        logic eer, er;
        int guard, lat;
        logic [N_OUT*32-1:0] snap;
        model_access(1'b0, 32'h0000_0010, 3'b010, 32'h0, erd, eer);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0010; req_op = 3'b010;
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = 32'h0000_0014; req_op = 3'b010; req_wdata = 32'h0BAD_0BAD;
        guard = 0;
        while (!rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b1, 1'b0, eer, erd}) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got valid=%b ready=%b err=%b rdata=%h, want 1 0 %b %h",
                         c, rsp_valid, req_ready, rsp_err, rsp_rdata, eer, erd);
            end
        end
        @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_release: got valid=%b, want 0", rsp_valid);
        end
        model_access(1'b0, 32'h0000_0014, 3'b010, 32'h0, junk, eer);
        do_txn(1'b0, 32'h0000_0014, 3'b010, 32'h0, 0, rd, er, lat, snap);
        tests_run++;
        if ({er, rd} !== {eer, junk}) begin
            tests_failed++;
            $display("FAIL stall_req_ignored: got err=%b rdata=%h, want %b %h", er, rd, eer, junk);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        logic [N_OUT*32-1:0] snap;
        run_txn(1'b1, 32'h0000_0020, 3'b010, 32'h1111_1111, 0, rd, er, lat, snap, erd, eer);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0020; req_op = 3'b010;
        req_wdata = 32'h2222_2222;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < N_OUT; k++) out_m[k] = 32'h0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({rsp_valid, req_ready} !== 2'b00) begin
                tests_failed++;
                $display("FAIL reset_mid_no_rsp[%0d]: got valid=%b ready=%b, want 0 0", c, rsp_valid, req_ready);
            end
        end
        tests_run++;
        if (io_out !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_io_out: got %h, want 0", io_out);
        end
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        run_txn(1'b0, 32'h0000_0020, 3'b010, 32'h0, 0, rd, er, lat, snap, erd, eer);
        tests_run++;
        if ({er, rd} !== {1'b0, 32'h1111_1111}) begin
            tests_failed++;
            $display("FAIL reset_mid_no_write: got err=%b rdata=%h, want 0 11111111", er, rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a;
        logic er, eer, we;
        logic [2:0] op;
        int lat;
        logic [N_OUT*32-1:0] snap;
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                io_in = $urandom;
                repeat (3) @(posedge clk);
            end
            a = $urandom;
            case ($urandom_range(0, 3))
                0: begin a[15:12] = 4'h0; a[9:2] = 8'($urandom_range(0, 7)); end
                1: begin a[15:12] = 4'h7; a[7:2] = 6'($urandom_range(0, 13)); end
                2: begin a[15:12] = 4'h8; a[7:2] = 6'($urandom_range(0, 2)); end
                default: a[15:12] = 4'($urandom_range(1, 6));
            endcase
            we = 1'($urandom);
            op = 3'($urandom_range(0, 7));
            run_txn(we, a, op, $urandom, $urandom_range(0, 2), rd, er, lat, snap, erd, eer);
            tests_run++;
            if ({er, rd} !== {eer, erd}) begin
                tests_failed++;
                $display("FAIL rand_rsp[%0d] we=%b addr=%h op=%b: got err=%b rdata=%h, want %b %h",
                         t, we, a, op, er, rd, eer, erd);
            end
            tests_run++;
            if (lat !== 1) begin
                tests_failed++;
                $display("FAIL rand_latency[%0d]: got %0d edges after accept, want 1", t, lat);
            end
            tests_run++;
            if (snap !== exp_io()) begin
                tests_failed++;
                $display("FAIL rand_io_out[%0d]: got %h, want %h", t, snap, exp_io());
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        for (int i = 0; i < DM_BYTES; i++) mem_m[i] = 8'h00;
        for (int k = 0; k < N_OUT; k++) out_m[k] = 32'h0;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_op = 3'b000; req_wdata = 32'h0;
        rsp_ready = 1'b0;
        io_in = '0;
        test_reset();
        test_directed();
        test_input();
        test_errors();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
